fb_write_scheduler: RTL and testbench

- Schedules the single-port 640x480 12-bit frame-buffer RAM between two users: pixel scanout for vga_ctrl, and a drawing engine that writes pixels.
- Scanout always owns the RAM during active video (valid=1).
- Drawing writes are buffered in a small FIFO and drained only during blanking (valid=0).
- Sits between vga_ctrl, the frame-buffer RAM (registered q, 1-cycle read latency) and the drawing logic.

---
 rtl/fb_write_scheduler_if.sv | 16 +
 rtl/fb_write_scheduler.sv | 140 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_scheduler_if.sv
// Drawing-engine write port of the frame-buffer scheduler.
// The drawing engine drives the master side, the scheduler is the slave.
interface fb_write_scheduler_if #(
    parameter int AW = 19,
    parameter int DW = 12
);
    // A write transfers on every pclk edge where wr_valid && wr_ready.
    // wr_addr/wr_data must be stable while wr_valid is high; wr_ready never depends on wr_valid.
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_write_scheduler.sv
// Shares the single-port frame-buffer RAM between VGA scanout (active video) and buffered drawing writes (blanking).
// Optional macro FB_STALL_CNT_EN adds a saturating stall_cnt output counting refused write requests.
module fb_write_scheduler #(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        pclk,
    input  logic                        reset,
    input  logic [9:0]                  h_addr,
    input  logic [9:0]                  v_addr,
    input  logic                        valid,
    fb_write_scheduler_if.slave         wr,
    output logic [AW-1:0]               mem_addr,
    output logic                        mem_we,
    output logic [DW-1:0]               mem_wdata,
    input  logic [DW-1:0]               mem_q,
    output logic [DW-1:0]               vga_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [1:0]                  state_dbg
`ifdef FB_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;
    logic [18:0]   rd_raw;
    logic [AW-1:0] rd_addr, addr_d;
    logic [DW-1:0] wdata_d;
    logic          we_d;
    logic          valid_d1, valid_d2;
    logic          unused_v_msb;

    // Row fits in 9 bits (480 lines), so the column lands at a 512-word stride.
    assign rd_raw       = {h_addr, v_addr[8:0]};
    assign rd_addr      = AW'(rd_raw);
    assign unused_v_msb = v_addr[9];

    assign full        = (count == (PW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign wr.wr_ready = !reset && !full;
    assign push        = wr.wr_valid && wr.wr_ready;
    assign fifo_level  = count;
    assign state_dbg   = state;

    always_ff @(posedge pclk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        if (valid)       next_state = SCAN;
        else if (!empty) next_state = DRAIN;
        else             next_state = IDLE;
    end

    always_comb begin
        pop     = 1'b0;
        we_d    = 1'b0;
        addr_d  = rd_addr;
        wdata_d = mem_wdata;
        if (next_state == DRAIN) begin
            pop     = 1'b1;
            we_d    = 1'b1;
            addr_d  = fifo_addr[rd_ptr];
            wdata_d = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_addr  <= addr_d;
            mem_we    <= we_d;
            mem_wdata <= wdata_d;
        end
    end

    // Storage needs no reset: pointers and count alone define the contents.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr.wr_addr;
            fifo_data[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // valid_d2 lines up with the RAM output, so write slots always blank the pixel.
    always_ff @(posedge pclk) begin
        if (reset) begin
            valid_d1 <= 1'b0;
            valid_d2 <= 1'b0;
            vga_data <= '0;
        end else begin
            valid_d1 <= valid;
            valid_d2 <= valid_d1;
            vga_data <= valid_d2 ? mem_q : '0;
        end
    end

`ifdef FB_STALL_CNT_EN
    always_ff @(posedge pclk) begin
        if (reset)
            stall_cnt <= '0;
        else if (wr.wr_valid && !wr.wr_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: vector table, directed corner sequences and a randomized run
// against a queue-based reference model. Define FB_STALL_CNT_EN to exercise the stall counter as well.
module tb_fb_write_scheduler;
    localparam int AW    = 19;
    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic          pclk = 1'b0;
    logic          reset;
    logic [9:0]    h_addr, v_addr;
    logic          valid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_q, vga_data;
    logic [2:0]    fifo_level;
    logic [1:0]    state_dbg;
`ifdef FB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    fb_write_scheduler_if #(.AW(AW), .DW(DW)) wr_if ();

    fb_write_scheduler #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .valid      (valid),
        .wr         (wr_if.slave),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_q      (mem_q),
        .vga_data   (vga_data),
        .fifo_level (fifo_level),
        .state_dbg  (state_dbg)
`ifdef FB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // clock / reset
    always #20 pclk = ~pclk;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // frame-buffer RAM: registered read, one cycle latency
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge pclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    // reference model state
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    mram [int];
    logic [DW-1:0]    vpipe [3];
    int               n_vec = 0;
    int               n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // one pclk cycle: drive inputs, predict, then sample after the edge
    task automatic step(input logic rst, input logic vld, input logic [9:0] h, input logic [9:0] v,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output logic o_ready, output logic o_we, output logic [AW-1:0] o_addr,
                        output logic [DW-1:0] o_wdata, output logic [2:0] o_level,
                        output logic [DW-1:0] o_vga);
        logic             e_we;
        logic [AW-1:0]    e_addr, rd;
        logic [DW-1:0]    e_wdata, e_vga;
        logic             acc;
        logic [AW+DW-1:0] ent;
        @(negedge pclk);
        reset          = rst;
        valid          = vld;
        h_addr         = h;
        v_addr         = v;
        wr_if.wr_valid = wv;
        wr_if.wr_addr  = wa;
        wr_if.wr_data  = wd;
        #1;
        o_ready = wr_if.wr_ready;
        chk("wr_ready", 32'(o_ready), 32'(!rst && exp_q.size() < DEPTH));
        e_we    = 1'b0;
        e_wdata = '0;
        e_addr  = '0;
        if (rst) begin
            exp_q.delete();
            for (int k = 0; k < 3; k++) vpipe[k] = '0;
        end else begin
            rd    = AW'(int'(h) * 512 + int'(v) % 512);
            acc   = wv && (exp_q.size() < DEPTH);
            e_vga = '0;
            if (vld) begin
                e_addr = rd;
                if (mram.exists(int'(rd))) e_vga = mram[int'(rd)];
            end else if (exp_q.size() > 0) begin
                ent     = exp_q.pop_front();
                e_we    = 1'b1;
                e_addr  = ent[AW+DW-1:DW];
                e_wdata = ent[DW-1:0];
                mram[int'(e_addr)] = e_wdata;
            end else begin
                e_addr = rd;
            end
            if (acc) exp_q.push_back({wa, wd});
            vpipe[2] = vpipe[1];
            vpipe[1] = vpipe[0];
            vpipe[0] = e_vga;
        end
        @(posedge pclk);
        #1;
        o_we    = mem_we;
        o_addr  = mem_addr;
        o_wdata = mem_wdata;
        o_level = fifo_level;
        o_vga   = vga_data;
        chk("mem_we", 32'(o_we), 32'(e_we));
        chk("mem_addr", 32'(o_addr), 32'(e_addr));
        if (e_we || rst) chk("mem_wdata", 32'(o_wdata), 32'(e_wdata));
        chk("fifo_level", 32'(o_level), 32'(exp_q.size()));
        chk("vga_data", 32'(o_vga), 32'(vpipe[2]));
    endtask

    typedef struct {
        logic          valid;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          e_ready;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [2:0]    e_level;
    } vec_t;

    vec_t          tbl [15];
    logic          o_ready, o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_vga;
    logic [2:0]    o_level;
    int            we_seen;
    logic          rv, rw;

    initial begin
        for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
        reset = 1'b1; valid = 1'b0; h_addr = '0; v_addr = '0;
        wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
        for (int k = 0; k < 3; k++) vpipe[k] = '0;

        // blanking drain, then active-video hold and release (h=v=0, so rd_addr=0)
        tbl[0]  = '{1'b0, 1'b1, 19'h00005, 12'hF00, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd1};
        tbl[1]  = '{1'b0, 1'b1, 19'h00A00, 12'h0F0, 1'b1, 1'b1, 19'h00005, 12'hF00, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 19'h4FFFF, 12'h00F, 1'b1, 1'b1, 19'h00A00, 12'h0F0, 3'd1};
        tbl[3]  = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b1, 1'b1, 19'h4FFFF, 12'h00F, 3'd0};
        tbl[4]  = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd0};
        tbl[5]  = '{1'b1, 1'b1, 19'h00100, 12'h123, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd1};
        tbl[6]  = '{1'b1, 1'b1, 19'h00101, 12'h456, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd2};
        tbl[7]  = '{1'b1, 1'b1, 19'h00102, 12'h789, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd3};
        tbl[8]  = '{1'b1, 1'b1, 19'h00103, 12'hABC, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd4};
        tbl[9]  = '{1'b1, 1'b1, 19'h001FF, 12'hEEE, 1'b0, 1'b0, 19'h00000, 12'h000, 3'd4};
        tbl[10] = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b0, 1'b1, 19'h00100, 12'h123, 3'd3};
        tbl[11] = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b1, 1'b1, 19'h00101, 12'h456, 3'd2};
        tbl[12] = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b1, 1'b1, 19'h00102, 12'h789, 3'd1};
        tbl[13] = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b1, 1'b1, 19'h00103, 12'hABC, 3'd0};
        tbl[14] = '{1'b0, 1'b0, 19'h00000, 12'h000, 1'b1, 1'b0, 19'h00000, 12'h000, 3'd0};

        // reset state
        step(1, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        step(1, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        chk("rst_vga", 32'(o_vga), 32'h0);
        chk("rst_level", 32'(o_level), 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(0, tbl[i].valid, 0, 0, tbl[i].wv, tbl[i].wa, tbl[i].wd,
                 o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
            chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_we", i), 32'(o_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i), 32'(o_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_we) chk($sformatf("tbl%0d_data", i), 32'(o_wdata), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_level", i), 32'(o_level), 32'(tbl[i].e_level));
        end

        // scanout latency: pixel at {h=10,v=20} shows up three cycles later
        ram[19'd5140] = 12'hABC;
        mram[5140]    = 12'hABC;
        step(0, 1, 10, 20, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        step(0, 1, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        step(0, 1, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        chk("scan_vga", 32'(o_vga), 32'hABC);
        step(0, 0, 10, 20, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        step(0, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        step(0, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        chk("blank_vga", 32'(o_vga), 32'h0);

        // preemption: 4 queued, two blanking cycles, then active video again
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 1, AW'(32'h200 + i), DW'(32'h300 + i), o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        we_seen = 0;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
            we_seen += int'(o_we);
        end
        step(0, 1, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        we_seen += int'(o_we);
        chk("preempt_writes", 32'(we_seen), 32'd2);
        chk("preempt_we", 32'(o_we), 32'h0);
        chk("preempt_level", 32'(o_level), 32'd2);
        step(0, 1, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        chk("preempt_drained", 32'(o_level), 32'd0);

        // reset mid-frame with two entries queued
        for (int i = 0; i < 2; i++)
            step(0, 1, 0, 0, 1, AW'(32'h7000 + i), 12'h5A5, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        step(0, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        chk("postrst_ready", 32'(o_ready), 32'h1);
        chk("postrst_we", 32'(o_we), 32'h0);
        chk("postrst_level", 32'(o_level), 32'h0);
        chk("postrst_vga", 32'(o_vga), 32'h0);
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
            we_seen += int'(o_we);
        end
        chk("discarded_writes", 32'(we_seen), 32'd0);

        // randomized traffic against the reference model
        rv = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) rv = ~rv;
            rw = ($urandom_range(0, 99) == 0);
            step(rw, rv, 10'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 3) * 512 + $urandom_range(0, 3)), DW'($urandom),
                 o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        end

`ifdef FB_STALL_CNT_EN
        step(1, 0, 0, 0, 0, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 1, AW'(i), 12'h111, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        repeat (70000) @(posedge pclk);
        #1;
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        repeat (5) @(posedge pclk);
        #1;
        chk("stall_hold", 32'(stall_cnt), 32'hFFFF);
        step(1, 1, 0, 0, 1, '0, '0, o_ready, o_we, o_addr, o_wdata, o_level, o_vga);
        chk("stall_rst", 32'(stall_cnt), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
